// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS core: constant encodings,
// reset defaults and the fetch-stage state type.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        HALT_WAIT = 2'd1,
        HALTED    = 2'd2
    } fetch_state_e;

    // Branch targets are byte addresses; instructions are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush (turn into a NOP bubble) wins over hold,
// hold wins over a normal load.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    input  logic        valid_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = valid_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the pipelined MIPS core: PC register, redirect/stall handling,
// halt-word detection with a drain counter, and the IF/ID register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted
);

    localparam int unsigned      CNT_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_DONE = CNT_W'(DRAIN_CYCLES);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_plus4;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ifid_hold;
    logic             ifid_flush;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // A halt word is latched like any instruction; the stage then freezes the
    // PC and feeds bubbles until the older instructions have drained.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d       = align_word(redirect_pc);
                    ifid_flush = 1'b1;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else if (imem_rdata == HALT_WORD) begin
                    state_d = HALT_WAIT;
                    cnt_d   = '0;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            HALT_WAIT: begin
                if (redirect) begin
                    pc_d       = align_word(redirect_pc);
                    ifid_flush = 1'b1;
                    state_d    = FETCH;
                    cnt_d      = '0;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else if (cnt_q == DRAIN_DONE) begin
                    ifid_flush = 1'b1;
                    state_d    = HALTED;
                end else begin
                    ifid_flush = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            HALTED: begin
                ifid_hold = 1'b1;
            end
            default: begin
                state_d    = FETCH;
                ifid_flush = 1'b1;
                cnt_d      = '0;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (ifid_hold),
        .flush_i (ifid_flush),
        .instr_i (imem_rdata),
        .pc4_i   (pc_plus4),
        .valid_i (1'b1),
        .instr_o (if_id_instr),
        .pc4_o   (if_id_pc4),
        .valid_o (if_id_valid)
    );

    assign imem_addr = pc_q[31:2];
    assign pc        = pc_q;
    assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized
// stall/redirect/reset traffic, checked through a scoreboard queue.
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam int          DRAIN = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [29:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;

    exp_t        expQ[$];
    logic [31:0] memOverride [logic [29:0]];
    int          checks = 0;
    int          errors = 0;
    event        checkNow;

    // Reference model state: program-level view of the fetch stage.
    logic [31:0] mPc, mInstr, mPc4;
    logic        mValid, mHalted, haltSeen;
    int          drainEdges;

    fetch_stage #(.RESET_PC(RPC), .DRAIN_CYCLES(DRAIN), .HALT_WORD(HALT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memRead(input logic [29:0] addr);
        if (memOverride.exists(addr)) return memOverride[addr];
        return {addr, 2'b00} ^ 32'h2400_1234;
    endfunction

    function automatic void modelReset();
        mPc        = RPC;
        mInstr     = 32'h0;
        mPc4       = 32'h0;
        mValid     = 1'b0;
        mHalted    = 1'b0;
        haltSeen   = 1'b0;
        drainEdges = 0;
    endfunction

    function automatic void makeBubble();
        mInstr = 32'h0;
        mPc4   = 32'h0;
        mValid = 1'b0;
    endfunction

    // Once a halt word is latched, halted rises on the (DRAIN+1)th
    // non-stalled edge; a redirect before then cancels the halt.
    function automatic void modelStep(input logic s, input logic r, input logic [31:0] rp);
        logic [31:0] word;
        if (mHalted) begin
        end else if (r) begin
            mPc        = {rp[31:2], 2'b00};
            haltSeen   = 1'b0;
            drainEdges = 0;
            makeBubble();
        end else if (s) begin
        end else if (haltSeen) begin
            drainEdges++;
            makeBubble();
            if (drainEdges == DRAIN + 1) mHalted = 1'b1;
        end else begin
            word   = memRead(mPc[31:2]);
            mInstr = word;
            mPc4   = mPc + 32'd4;
            mValid = 1'b1;
            if (word == HALT) begin
                haltSeen   = 1'b1;
                drainEdges = 0;
            end else begin
                mPc = mPc + 32'd4;
            end
        end
    endfunction

    function automatic void pushExp();
        exp_t e;
        e.pc     = mPc;
        e.instr  = mInstr;
        e.pc4    = mPc4;
        e.valid  = mValid;
        e.halted = mHalted;
        expQ.push_back(e);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check32("pc", pc, e.pc);
        check32("imem_addr", {2'b00, imem_addr}, {2'b00, e.pc[31:2]});
        check32("if_id_instr", if_id_instr, e.instr);
        check32("if_id_pc4", if_id_pc4, e.pc4);
        check32("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
        check32("halted", {31'h0, halted}, {31'h0, e.halted});
    endtask

    // Monitor: compares after every edge and on demand for asynchronous reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or checkNow);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rp);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        imem_rdata  = memRead(imem_addr);
        modelStep(s, r, rp);
        pushExp();
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        #1;
        rst_n = 1'b0;
        modelReset();
        pushExp();
        ->checkNow;
        #3;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic        s, r;
        logic [31:0] rp;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_rdata  = 32'h0;
        memOverride[30'h0] = 32'h2008_0005;
        memOverride[30'h1] = 32'h2009_0003;
        modelReset();
        #2;
        pushExp();
        ->checkNow;
        #5;
        rst_n = 1'b1;

        // Free run, then a two-edge stall at pc 8 and resume.
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Halt at pc 12, drain, then redirect pulses must be ignored.
        memOverride[30'h3] = HALT;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h100);
        applyStimulus(1'b1, 1'b1, 32'h80);
        applyStimulus(1'b0, 1'b0, 32'h0);

        doReset();
        applyStimulus(1'b1, 1'b1, 32'h0000_0043);

        // Halt on a wrong path, cancelled by a redirect.
        memOverride[30'h10] = HALT;
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h20);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);

        // PC wrap from the top of the address space.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        memOverride[30'h07] = HALT;
        memOverride[30'h19] = HALT;
        memOverride[30'h2a] = HALT;
        for (int i = 0; i < 500; i++) begin
            if ((mHalted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                s  = ($urandom_range(0, 3) == 0);
                r  = ($urandom_range(0, 9) == 0);
                rp = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
                applyStimulus(s, r, rp);
            end
        end

        stall    = 1'b0;
        redirect = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
